alu_cmd_ctrl: RTL and testbench
===============================

# alu_cmd_ctrl

Command front-end for the ALU: it parses ALU command frames from the UART receive byte stream and loads operands and function code into registered ALU inputs. It fires the ALU for one cycle, captures the 16-bit result and returns it low byte first to the UART transmitter with a busy/valid handshake. It sits directly upstream of the ALU, which consumes ALU_A/ALU_B/ALU_FUN/ALU_EN, and downstream of it, taking ALU_OUT/OUT_VALID back.

## Interface
- DATA_WIDTH, 8, operand and byte width
- RES_WIDTH, 2*DATA_WIDTH, ALU result width
- CMD_OPER, 8'hCC, command byte: A, B, FUN follow
- CMD_NOPR, 8'hDD, command byte: FUN follows; last A/B reused
- WDOG_CYC, 4, max cycles from ALU_EN to ALU_OUT_VLD

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
- ALU_A  out  DATA_WIDTH  operand A (registered)
- ALU_B  out  DATA_WIDTH  operand B (registered)
- ALU_FUN  out  4  function code (registered)
- ALU_EN  out  1  one-cycle ALU fire strobe
- ALU_OUT  in  RES_WIDTH  ALU result
- ALU_OUT_VLD  in  1  ALU result valid
- TX_P_DATA  out  DATA_WIDTH  byte to transmitter
- TX_D_VLD  out  1  TX_P_DATA valid, held until accepted
- TX_BUSY  in  1  transmitter busy; rising while TX_D_VLD=1 = accept
- CMD_ERR  out  1  one-cycle error strobe

## Operation
- States: IDLE, GET_A, GET_B, GET_FUN, ALU_WAIT, SEND_LO, SEND_HI.
- IDLE: RX byte == CMD_OPER -> GET_A; == CMD_NOPR -> GET_FUN; any other byte -> CMD_ERR pulse, stay IDLE.
- GET_A / GET_B: on RX_D_VLD load ALU_A / ALU_B, advance.
- GET_FUN: on RX_D_VLD load ALU_FUN = RX_P_DATA[3:0] (upper nibble ignored); assert ALU_EN for the next cycle only; -> ALU_WAIT; clear watchdog.
- ALU_WAIT: on ALU_OUT_VLD capture ALU_OUT into result reg -> SEND_LO. If watchdog reaches WDOG_CYC without ALU_OUT_VLD -> CMD_ERR pulse, IDLE, nothing transmitted.
- SEND_LO: when TX_BUSY=0 drive TX_P_DATA=result[7:0], TX_D_VLD=1; hold both until TX_BUSY samples 1, then drop TX_D_VLD -> SEND_HI.
- SEND_HI: wait TX_BUSY=0, send result[15:8] with the same rule; on accept -> IDLE.
- RX_D_VLD in ALU_WAIT/SEND_LO/SEND_HI: byte dropped, CMD_ERR pulse, FSM unaffected.
- ALU_A/ALU_B/ALU_FUN persist across commands; only overwritten by new bytes.
- RX_D_VLD and ALU_OUT_VLD in the same cycle in ALU_WAIT: result captured, byte dropped with CMD_ERR.

## Timing
- Reset (RST=1, async): state IDLE; ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR, result, watchdog all 0. Reset mid-frame or mid-send aborts silently; TX_D_VLD drops immediately.
- All outputs are registered; no combinational path from inputs to outputs.
- FUN byte strobe in cycle t -> ALU_EN=1 in cycle t+1 with ALU_A/B/FUN stable -> ALU_OUT_VLD expected in t+2.
- ALU_OUT_VLD at cycle u -> TX_D_VLD=1 at u+1 if TX_BUSY=0.
- Back-to-back frames: first byte of the next frame is accepted the cycle after the high-byte accept.

## Structure
- Package alu_ctrl_pkg: state enum, CMD_OPER/CMD_NOPR defaults, WDOG_CYC default, watchdog width.
- No sub-module: single FSM with inline watchdog counter and result register.

## Test plan
- Bytes CC,05,03,00; ALU returns 0x0008 next cycle -> ALU_A=05, ALU_B=03, ALU_FUN=0, one ALU_EN pulse; TX bytes 08 then 00.
- Then DD,02; ALU returns 0x000F -> ALU_A/B still 05/03, FUN=2; TX 0F, 00.
- IDLE byte 0x55 -> one CMD_ERR pulse, no ALU_EN, state IDLE; following CC frame processed normally.
- CC,01,02,07 with ALU_OUT_VLD never asserted -> CMD_ERR 4 cycles after ALU_EN, no TX_D_VLD, IDLE.
- TX_BUSY held high 20 cycles before SEND_LO -> TX_D_VLD stays 0; then held 1 with TX_P_DATA stable until TX_BUSY rises; RX byte during send -> CMD_ERR, send completes.
- RST pulsed during GET_B and during SEND_HI -> all outputs 0 immediately; next full frame works.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: FSM states and command constants shared by alu_cmd_ctrl
package alu_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, GET_A, GET_B, GET_FUN, ALU_WAIT, SEND_LO, SEND_HI} state_t;
  localparam logic [7:0] CMD_OPER_DEF = 8'hCC;
  localparam logic [7:0] CMD_NOPR_DEF = 8'hDD;
  localparam int WDOG_CYC_DEF = 4;
  localparam int WDOG_W = $clog2(WDOG_CYC_DEF + 1);
endpackage

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: parses UART ALU command frames, fires the ALU and returns its result low byte first
import alu_ctrl_pkg::*;
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH = 2 * DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CMD_OPER = CMD_OPER_DEF,
  parameter logic [DATA_WIDTH-1:0] CMD_NOPR = CMD_NOPR_DEF,
  parameter int WDOG_CYC = WDOG_CYC_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  input  logic [RES_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY,
  output logic                  CMD_ERR
);
  localparam int WD_W = (WDOG_CYC > WDOG_CYC_DEF) ? $clog2(WDOG_CYC + 1) : WDOG_W;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, tx_data_q, tx_data_d;
  logic [3:0] fun_q, fun_d;
  logic [RES_WIDTH-1:0] res_q, res_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic en_q, en_d, tx_vld_q, tx_vld_d, err_q, err_d;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    fun_d = fun_q;
    res_d = res_q;
    wd_d = wd_q;
    tx_data_d = tx_data_q;
    tx_vld_d = tx_vld_q;
    en_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (RX_D_VLD) begin
        state_d = (RX_P_DATA == CMD_OPER) ? GET_A : (RX_P_DATA == CMD_NOPR) ? GET_FUN : IDLE;
        err_d = (RX_P_DATA != CMD_OPER) && (RX_P_DATA != CMD_NOPR);
      end
      GET_A: if (RX_D_VLD) begin
        a_d = RX_P_DATA;
        state_d = GET_B;
      end
      GET_B: if (RX_D_VLD) begin
        b_d = RX_P_DATA;
        state_d = GET_FUN;
      end
      GET_FUN: if (RX_D_VLD) begin
        fun_d = RX_P_DATA[3:0];
        en_d = 1'b1;
        wd_d = '0;
        state_d = ALU_WAIT;
      end
      ALU_WAIT: begin
        err_d = RX_D_VLD;
        if (ALU_OUT_VLD) begin
          res_d = ALU_OUT;
          state_d = SEND_LO;
          // Present the low byte straight away so it appears the cycle after the result
          tx_vld_d = !TX_BUSY;
          tx_data_d = TX_BUSY ? tx_data_q : ALU_OUT[DATA_WIDTH-1:0];
        end else if (wd_q == WD_W'(WDOG_CYC - 1)) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      SEND_LO, SEND_HI: begin
        err_d = RX_D_VLD;
        if (tx_vld_q && TX_BUSY) begin
          tx_vld_d = 1'b0;
          state_d = (state_q == SEND_LO) ? SEND_HI : IDLE;
        end else if (!tx_vld_q && !TX_BUSY) begin
          tx_vld_d = 1'b1;
          tx_data_d = (state_q == SEND_LO) ? res_q[DATA_WIDTH-1:0] : res_q[RES_WIDTH-1:DATA_WIDTH];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      fun_q <= '0;
      res_q <= '0;
      wd_q <= '0;
      tx_data_q <= '0;
      tx_vld_q <= 1'b0;
      en_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      fun_q <= fun_d;
      res_q <= res_d;
      wd_q <= wd_d;
      tx_data_q <= tx_data_d;
      tx_vld_q <= tx_vld_d;
      en_q <= en_d;
      err_q <= err_d;
    end
  end
  assign ALU_A = a_q;
  assign ALU_B = b_q;
  assign ALU_FUN = fun_q;
  assign ALU_EN = en_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD = tx_vld_q;
  assign CMD_ERR = err_q;
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: table, hand-written and random frames against a frame-level reference model
`timescale 1ns/1ps
module tb_alu_cmd_ctrl;
  logic CLK = 1'b0, RST = 1'b1;
  logic [7:0] RX_P_DATA = '0;
  logic RX_D_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic ALU_OUT_VLD = 1'b0;
  logic TX_BUSY = 1'b0;
  logic [7:0] ALU_A, ALU_B, TX_P_DATA;
  logic [3:0] ALU_FUN;
  logic ALU_EN, TX_D_VLD, CMD_ERR;
  int checks = 0, errors = 0, err_cnt = 0, en_cnt = 0;
  logic mute = 1'b0, en_d1 = 1'b0;
  typedef struct {
    logic [31:0] bytes;
    int n;
    logic [7:0] a, b;
    logic [3:0] f;
    logic [15:0] res;
    int errs;
    bit tx;
  } vec_t;
  vec_t tbl [8];
  logic [7:0] ma = '0, mb = '0;
  logic [3:0] mf = '0;

  alu_cmd_ctrl dut (.CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .ALU_OUT(ALU_OUT),
    .ALU_OUT_VLD(ALU_OUT_VLD), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
    .CMD_ERR(CMD_ERR));

  always #5 CLK = ~CLK;

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0: return {8'h00, a} + {8'h00, b};
      4'd1: return {8'h00, a} - {8'h00, b};
      4'd2: return {8'h00, a} * {8'h00, b};
      4'd3: return {a, b};
      default: return {8'h00, a ^ b};
    endcase
  endfunction

  // ALU stand-in: result valid two cycles after the FUN byte strobe
  always @(negedge CLK) begin
    en_d1 <= ALU_EN;
    ALU_OUT_VLD <= en_d1 && !mute;
    ALU_OUT <= alu_fn(ALU_A, ALU_B, ALU_FUN);
  end

  always @(negedge CLK) begin
    err_cnt <= err_cnt + int'(CMD_ERR);
    en_cnt <= en_cnt + int'(ALU_EN);
  end

  task automatic tick;
    @(negedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {2'b00, ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR}, 32'h0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    tick;
    RX_D_VLD = 1'b0;
  endtask

  task automatic recv_byte(input logic [7:0] exp, input int hold);
    int n;
    n = 0;
    while (!TX_D_VLD && n < 50) begin
      tick;
      n++;
    end
    chk("tx_vld_wait", TX_D_VLD, 1);
    chk("tx_data", TX_P_DATA, exp);
    for (int h = 0; h < hold; h++) begin
      tick;
      chk("tx_hold", {TX_D_VLD, TX_P_DATA}, {1'b1, exp});
    end
    TX_BUSY = 1'b1;
    tick;
    chk("tx_drop", TX_D_VLD, 0);
    TX_BUSY = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    int e0, n0;
    logic [31:0] bv;
    e0 = err_cnt;
    n0 = en_cnt;
    bv = v.bytes;
    for (int j = 0; j < v.n; j++) send_byte(bv[31-8*j -: 8]);
    chk("alu_en_cycle", ALU_EN, v.tx);
    if (v.tx) begin
      recv_byte(v.res[7:0], hold);
      recv_byte(v.res[15:8], hold);
    end else begin
      tick;
    end
    chk("alu_a", ALU_A, v.a);
    chk("alu_b", ALU_B, v.b);
    chk("alu_fun", ALU_FUN, v.f);
    chk("cmd_err_cnt", err_cnt - e0, v.errs);
    chk("alu_en_cnt", en_cnt - n0, v.tx);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int seen;
    vec_t v;
    logic [7:0] fb;
    tbl[0] = '{32'hCC050300, 4, 8'h05, 8'h03, 4'h0, 16'h0008, 0, 1};
    tbl[1] = '{32'hDD020000, 2, 8'h05, 8'h03, 4'h2, 16'h000F, 0, 1};
    tbl[2] = '{32'h55000000, 1, 8'h05, 8'h03, 4'h2, 16'h0000, 1, 0};
    tbl[3] = '{32'hCC102003, 4, 8'h10, 8'h20, 4'h3, 16'h1020, 0, 1};
    tbl[4] = '{32'hDD1A0000, 2, 8'h10, 8'h20, 4'hA, 16'h0030, 0, 1};
    tbl[5] = '{32'h00000000, 1, 8'h10, 8'h20, 4'hA, 16'h0000, 1, 0};
    tbl[6] = '{32'hCCFF0201, 4, 8'hFF, 8'h02, 4'h1, 16'h00FD, 0, 1};
    tbl[7] = '{32'hCCFFFF02, 4, 8'hFF, 8'hFF, 4'h2, 16'hFE01, 0, 1};
    tick;
    tick;
    chk_zero("reset_outputs");
    RST = 1'b0;
    tick;
    foreach (tbl[i]) run_vec(tbl[i], i % 3);

    // ALU result to TX latency
    send_byte(8'hCC); send_byte(8'h06); send_byte(8'h01); send_byte(8'h00);
    chk("lat_alu_en", ALU_EN, 1);
    tick;
    chk("lat_tx_early", TX_D_VLD, 0);
    tick;
    chk("lat_tx_vld", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h07});
    recv_byte(8'h07, 0);
    recv_byte(8'h00, 0);

    // watchdog expiry with no ALU response
    mute = 1'b1;
    send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h07);
    chk("wd_alu_en", ALU_EN, 1);
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick;
      seen += int'(CMD_ERR) + int'(TX_D_VLD);
    end
    chk("wd_early", seen, 0);
    tick;
    chk("wd_err", {CMD_ERR, TX_D_VLD}, 2'b10);
    tick;
    chk("wd_after", {CMD_ERR, TX_D_VLD}, 2'b00);
    mute = 1'b0;
    run_vec('{32'hCC010207, 4, 8'h01, 8'h02, 4'h7, 16'h0003, 0, 1}, 0);

    // transmitter busy before the low byte, plus a stray RX byte during the send
    TX_BUSY = 1'b1;
    send_byte(8'hCC); send_byte(8'h09); send_byte(8'h04); send_byte(8'h00);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      seen += int'(TX_D_VLD);
    end
    chk("busy_no_vld", seen, 0);
    TX_BUSY = 1'b0;
    tick;
    chk("busy_release", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h0D});
    seen = err_cnt;
    send_byte(8'h77);
    chk("send_rx_err", {CMD_ERR, TX_D_VLD, TX_P_DATA}, {2'b11, 8'h0D});
    recv_byte(8'h0D, 2);
    recv_byte(8'h00, 0);
    chk("send_rx_err_cnt", err_cnt - seen, 1);
    chk("busy_regs", {ALU_A, ALU_B, ALU_FUN}, {8'h09, 8'h04, 4'h0});

    // reset while collecting operand B
    send_byte(8'hCC); send_byte(8'h11);
    RST = 1'b1;
    #1;
    chk_zero("rst_get_b");
    tick;
    RST = 1'b0;
    run_vec('{32'hCC030401, 4, 8'h03, 8'h04, 4'h1, 16'hFFFF, 0, 1}, 1);

    // reset while the high byte is on offer
    send_byte(8'hCC); send_byte(8'h02); send_byte(8'h02); send_byte(8'h00);
    recv_byte(8'h04, 0);
    tick;
    chk("hi_vld", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h00});
    RST = 1'b1;
    #1;
    chk_zero("rst_send_hi");
    tick;
    RST = 1'b0;
    run_vec('{32'hDD130000, 2, 8'h00, 8'h00, 4'h3, 16'h0000, 0, 1}, 0);
    ma = 8'h00; mb = 8'h00; mf = 4'h3;

    // random frames against the frame-level model
    for (int k = 0; k < 40; k++) begin
      int kind;
      kind = int'($urandom_range(0, 5));
      fb = 8'($urandom);
      if (kind == 0) begin
        while (fb == 8'hCC || fb == 8'hDD) fb = 8'($urandom);
        v = '{{fb, 24'h0}, 1, ma, mb, mf, 16'h0, 1, 0};
      end else begin
        if (kind <= 3) begin
          ma = 8'($urandom);
          mb = 8'($urandom);
        end
        mf = fb[3:0];
        v = (kind <= 3) ? '{{8'hCC, ma, mb, fb}, 4, ma, mb, mf, alu_fn(ma, mb, mf), 0, 1}
                        : '{{8'hDD, fb, 16'h0}, 2, ma, mb, mf, alu_fn(ma, mb, mf), 0, 1};
      end
      run_vec(v, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
